// File: rtl/bcd_press_counter.sv
// Two-digit BCD press counter: three raw buttons are synchronised, debounced and
// edge-detected, then drive a 00-99 up/down/clear count with a wrap pulse.
module bcd_press_counter #(
    parameter int unsigned DEBOUNCE_LIMIT = 250000
) (
    input  logic       i_Clk,
    input  logic       i_Rst_L,
    input  logic       i_Switch_Up,
    input  logic       i_Switch_Down,
    input  logic       i_Switch_Clr,
    output logic [3:0] o_Ones,
    output logic [3:0] o_Tens,
    output logic       o_Wrap
);

    localparam int unsigned NB    = 3;
    localparam int unsigned CNT_W = (DEBOUNCE_LIMIT > 1) ? $clog2(DEBOUNCE_LIMIT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_LIMIT - 1);

    logic [NB-1:0]    raw_c;
    logic [NB-1:0]    sync1_q, sync2_q;
    logic [NB-1:0]    state_q, state_d;
    logic [NB-1:0]    state_dly_q;
    logic [CNT_W-1:0] cnt_q [NB];
    logic [CNT_W-1:0] cnt_d [NB];
    logic [NB-1:0]    press_c;
    logic             up_c, dn_c, clr_c;
    logic [3:0]       ones_q, ones_d;
    logic [3:0]       tens_q, tens_d;
    logic             wrap_q, wrap_d;

    // Bit 0 = up, bit 1 = down, bit 2 = clear.
    assign raw_c = {i_Switch_Clr, i_Switch_Down, i_Switch_Up};

    // Debounce: the accepted level only follows after LIMIT consecutive differing samples.
    always_comb begin
        state_d = state_q;
        for (int unsigned i = 0; i < NB; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != state_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    state_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    assign press_c = state_q & ~state_dly_q;
    assign up_c    = press_c[0];
    assign dn_c    = press_c[1];
    assign clr_c   = press_c[2];

    // Count update: clear dominates, coincident up+down cancel.
    always_comb begin
        ones_d = ones_q;
        tens_d = tens_q;
        wrap_d = 1'b0;
        if (clr_c) begin
            ones_d = 4'd0;
            tens_d = 4'd0;
        end else if (up_c && !dn_c) begin
            if (ones_q < 4'd9) begin
                ones_d = ones_q + 4'd1;
            end else begin
                ones_d = 4'd0;
                if (tens_q < 4'd9) begin
                    tens_d = tens_q + 4'd1;
                end else begin
                    tens_d = 4'd0;
                    wrap_d = 1'b1;
                end
            end
        end else if (dn_c && !up_c) begin
            if (ones_q > 4'd0) begin
                ones_d = ones_q - 4'd1;
            end else begin
                ones_d = 4'd9;
                if (tens_q > 4'd0) begin
                    tens_d = tens_q - 4'd1;
                end else begin
                    tens_d = 4'd9;
                    wrap_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            state_q     <= '0;
            state_dly_q <= '0;
            for (int unsigned i = 0; i < NB; i++) begin
                cnt_q[i] <= '0;
            end
            ones_q      <= 4'd0;
            tens_q      <= 4'd0;
            wrap_q      <= 1'b0;
        end else begin
            sync1_q     <= raw_c;
            sync2_q     <= sync1_q;
            state_q     <= state_d;
            state_dly_q <= state_q;
            for (int unsigned i = 0; i < NB; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            ones_q      <= ones_d;
            tens_q      <= tens_d;
            wrap_q      <= wrap_d;
        end
    end

    assign o_Ones = ones_q;
    assign o_Tens = tens_q;
    assign o_Wrap = wrap_q;

endmodule
